dlx_mem_arb: RTL and testbench

//  Arbitrates the single external memory port between I-cache line refills and D-cache accesses.
//  An I-cache refill is a burst of IC_LINE_WORDS words; a D-cache access is a single-word read or write.
//  ic_busy feeds the IF stage stall.
//  D-side has priority; a streak limiter guarantees I-side forward progress.

---
 rtl/dlx_mem_arb.sv | 153 +++++++++++++++
 tb/tb_dlx_mem_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_mem_arb.sv
// Shares one external memory port between I-cache line refills (bursts) and single-word D-cache accesses.
// D-side wins ties until MAX_DC_STREAK consecutive D grants have starved a pending refill.
module dlx_mem_arb #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int IC_LINE_WORDS = 4,
    parameter int MAX_DC_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    output logic              ic_busy,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEAT_W   = $clog2(IC_LINE_WORDS);
    localparam int STREAK_W = $clog2(MAX_DC_STREAK + 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(IC_LINE_WORDS - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DC_STREAK);
    localparam logic [ADDR_W-1:0]   LINE_MASK  = ~ADDR_W'(4 * IC_LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]   WORD_STEP  = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IC_BURST = 2'd1,
        S_DC_ACC   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic dc_wins;
    logic last_beat;

    // D gets the port unless a refill is waiting and the D streak is exhausted.
    assign dc_wins   = dc_req && (!ic_req || (streak_q < STREAK_MAX));
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        streak_d    = ic_req ? streak_q : '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (dc_wins) begin
                    state_d     = S_DC_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dc_we;
                    mem_addr_d  = dc_addr;
                    mem_wdata_d = dc_wdata;
                    if (ic_req) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (ic_req) begin
                    state_d     = S_IC_BURST;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ic_addr & LINE_MASK;
                    mem_wdata_d = '0;
                    beat_d      = '0;
                    streak_d    = '0;
                end
            end

            S_IC_BURST: begin
                if (mem_ready) begin
                    if (last_beat) begin
                        state_d   = S_IDLE;
                        beat_d    = '0;
                        mem_req_d = 1'b0;
                    end else begin
                        beat_d     = beat_q + BEAT_W'(1);
                        mem_addr_d = mem_addr_q + WORD_STEP;
                    end
                end
            end

            S_DC_ACC: begin
                if (mem_ready) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                beat_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign ic_busy   = (state_q == S_IC_BURST);
    assign ic_rvalid = ic_busy && mem_ready;
    assign ic_done   = ic_rvalid && last_beat;
    assign ic_rdata  = mem_rdata;

    assign dc_ack    = (state_q == S_DC_ACC) && mem_ready;
    assign dc_rdata  = mem_rdata;

endmodule

// File: tb/tb_dlx_mem_arb.sv
// Scoreboard bench for dlx_mem_arb: stimulus queues expected memory beats, a monitor checks each transfer.
module tb_dlx_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] ic_rdata;
    logic        ic_rvalid, ic_done, ic_busy;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic [31:0] dc_rdata;
    logic        dc_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] rd_val = '0;

    int waits = 0;
    int wcnt = 0;
    bit hold_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_ic;
        bit          done;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    dlx_mem_arb #(
        .ADDR_W(32), .DATA_W(32), .IC_LINE_WORDS(4), .MAX_DC_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done), .ic_busy(ic_busy),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(rd_val)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input bit last, input logic [31:0] rd);
        exp_t x;
        x.is_ic = 1'b1; x.done = last; x.we = 1'b0; x.addr = a;
        x.wdata = '0; x.chk_rd = 1'b1; x.rdata = rd;
        exp_q.push_back(x);
    endtask

    task automatic push_ic(input logic [31:0] base, input logic [31:0] rd);
        for (int k = 0; k < 4; k++) push_beat(base + 32'(4 * k), (k == 3), rd);
    endtask

    task automatic push_dc(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input bit chk, input logic [31:0] rd);
        exp_t x;
        x.is_ic = 1'b0; x.done = 1'b0; x.we = we; x.addr = a;
        x.wdata = d; x.chk_rd = chk; x.rdata = rd;
        exp_q.push_back(x);
    endtask

    // Memory model: ready after `waits` stall cycles per beat.
    always @(negedge clk) begin
        mem_ready = mem_req && !hold_ready && (wcnt >= waits);
        if (mem_req && !mem_ready) wcnt++;
        else wcnt = 0;
    end

    logic        stall_prev = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check1("spurious_strobe", (ic_rvalid | ic_done | dc_ack) & ~(mem_req & mem_ready), 1'b0);
            if (stall_prev && mem_req) begin
                check32("hold_addr", mem_addr, p_addr);
                check1("hold_we", mem_we, p_we);
                check32("hold_wdata", mem_wdata, p_wdata);
            end
            if (mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual_addr=0x%08h required=none", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check32("mem_addr", mem_addr, e.addr);
                    check1("mem_we", mem_we, e.we);
                    check1("grant_kind_ic", ic_rvalid, e.is_ic);
                    if (e.is_ic) begin
                        check1("ic_done", ic_done, e.done);
                        check1("dc_ack_in_burst", dc_ack, 1'b0);
                        check32("ic_rdata", ic_rdata, e.rdata);
                    end else begin
                        check1("dc_ack", dc_ack, 1'b1);
                        if (e.we) check32("mem_wdata", mem_wdata, e.wdata);
                        if (e.chk_rd) check32("dc_rdata", dc_rdata, e.rdata);
                    end
                    $display("beat %s addr=0x%08h we=%b wdata=0x%08h rdata=0x%08h",
                             e.is_ic ? "IC" : "DC", mem_addr, mem_we, mem_wdata, rd_val);
                end
            end
            stall_prev = mem_req && !mem_ready;
            p_addr = mem_addr;
            p_we = mem_we;
            p_wdata = mem_wdata;
        end
    end

    task automatic wait_ic(output int busy, output bit ok);
        busy = 0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (ic_busy) busy++;
            if (ic_done) begin
                ok = 1'b1;
                break;
            end
        end
        check1("ic_done_timeout", ok, 1'b1);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (dc_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check1("dc_ack_timeout", ok, 1'b1);
    endtask

    task automatic ic_burst(input logic [31:0] a, input int w, input int busy_exp);
        int  busy;
        bit  ok;
        waits = w;
        @(posedge clk);
        #2;
        ic_addr = a;
        ic_req = 1'b1;
        wait_ic(busy, ok);
        check32("ic_busy_cycles", 32'(busy), 32'(busy_exp));
        @(posedge clk);
        #2;
        ic_req = 1'b0;
        ic_addr = 32'h0BAD_0000;
        @(negedge clk);
        #1;
        check1("ic_busy_after", ic_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  we_cyc, acks, cnt, busy;
        bit  ok;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check1("rst_ic_busy", ic_busy, 1'b0);
        check1("rst_ic_rvalid", ic_rvalid, 1'b0);
        check1("rst_ic_done", ic_done, 1'b0);
        check1("rst_dc_ack", dc_ack, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Plain refill of line 0x100.
        rd_val = 32'hCAFE_0100;
        push_ic(32'h0000_0100, 32'hCAFE_0100);
        ic_burst(32'h0000_0100, 0, 4);

        // D write with three wait states; inputs are scrambled after grant.
        push_dc(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 32'h0);
        waits = 3;
        @(posedge clk);
        #2;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_2000; dc_wdata = 32'hDEAD_BEEF;
        we_cyc = 0;
        acks = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (c == 1) begin
                dc_addr = 32'h5555_0000;
                dc_wdata = 32'h0123_4567;
                dc_we = 1'b0;
            end
            if (mem_req && mem_we) we_cyc++;
            if (dc_ack) begin
                acks++;
                break;
            end
        end
        @(posedge clk);
        #2;
        dc_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (dc_ack) acks++;
        end
        check32("dc_write_we_cycles", 32'(we_cyc), 32'd4);
        check32("dc_write_acks", 32'(acks), 32'd1);

        // Streak limiter: continuous D traffic against two pending refills.
        waits = 0;
        rd_val = 32'h0;
        for (int i = 0; i < 4; i++) push_dc(1'b1, 32'h2100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0, 32'h0);
        push_ic(32'h0000_0300, 32'h0);
        for (int i = 4; i < 8; i++) push_dc(1'b1, 32'h2100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0, 32'h0);
        push_ic(32'h0000_0400, 32'h0);
        @(posedge clk);
        #2;
        fork
            begin : dc_drv
                bit okd;
                for (int i = 0; i < 8; i++) begin
                    dc_req = 1'b1;
                    dc_we = 1'b1;
                    dc_addr = 32'h2100 + 32'(4 * i);
                    dc_wdata = 32'h1111_0000 + 32'(i);
                    wait_ack(okd);
                    @(posedge clk);
                    #2;
                    if (!okd) break;
                end
                dc_req = 1'b0;
            end
            begin : ic_drv
                int  bi;
                bit  oki;
                for (int j = 0; j < 2; j++) begin
                    ic_req = 1'b1;
                    ic_addr = (j == 0) ? 32'h0000_0300 : 32'h0000_0400;
                    wait_ic(bi, oki);
                    @(posedge clk);
                    #2;
                    if (!oki) break;
                end
                ic_req = 1'b0;
            end
        join
        check32("streak_queue_drained", 32'(exp_q.size()), 32'd0);

        // Address alignment and top-of-space line.
        rd_val = 32'h0F0F_0F0F;
        push_ic(32'hFFFF_FFF0, 32'h0F0F_0F0F);
        ic_burst(32'hFFFF_FFF4, 0, 4);
        push_ic(32'h0000_0100, 32'h0F0F_0F0F);
        ic_burst(32'h0000_0106, 1, 8);

        // Reset after two beats of a refill, then restart from beat 0.
        waits = 0;
        rd_val = 32'h0000_0500;
        push_beat(32'h0000_0500, 1'b0, 32'h0000_0500);
        push_beat(32'h0000_0504, 1'b0, 32'h0000_0500);
        push_ic(32'h0000_0500, 32'h0000_0500);
        @(posedge clk);
        #2;
        ic_addr = 32'h0000_0508;
        ic_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (ic_rvalid) cnt++;
            if (cnt == 2) break;
        end
        check32("rst_test_beats_before", 32'(cnt), 32'd2);
        @(posedge clk);
        #2;
        hold_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check1("midrst_mem_req", mem_req, 1'b0);
        check1("midrst_ic_busy", ic_busy, 1'b0);
        check1("midrst_ic_done", ic_done, 1'b0);
        #1;
        rst = 1'b0;
        hold_ready = 1'b0;
        wait_ic(busy, ok);
        check32("restart_busy_cycles", 32'(busy), 32'd4);
        @(posedge clk);
        #2;
        ic_req = 1'b0;

        // Back-to-back D reads.
        rd_val = 32'h0000_1234;
        push_dc(1'b0, 32'h0000_3000, 32'h0, 1'b1, 32'h0000_1234);
        push_dc(1'b0, 32'h0000_3004, 32'h0, 1'b1, 32'h0000_1234);
        @(posedge clk);
        #2;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_3000;
        wait_ack(ok);
        @(posedge clk);
        #2;
        dc_addr = 32'h0000_3004;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            cnt++;
            if (dc_ack) break;
        end
        check32("b2b_ack_spacing", 32'(cnt), 32'd2);
        @(posedge clk);
        #2;
        dc_req = 1'b0;

        repeat (5) @(posedge clk);
        #2;
        check32("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
